// File: rtl/fetch_redirect_pkg.sv
// fetch_redirect shared types: state encoding, FD bundle, reset constants.
// Imported by the fetch PC/FD-latch owner, its skid buffer and imem interface.
package fetch_redirect_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD     = '0;
  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
    logic            valid;
  } fd_t;

endpackage

// File: rtl/fetch_redirect_if.sv
// Instruction-memory request/response channel: one outstanding request,
// variable-latency valid strobe.
interface fetch_redirect_if;
  import fetch_redirect_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, ir, valid} holding register for a response that
// arrives while FD is stalled.
module fetch_skid_buf
  import fetch_redirect_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_WORD
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_ir,
  output fd_t             q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '{pc: '0, ir: NOP, valid: 1'b0};
    end else if (clear || drain) begin
      q <= '{pc: '0, ir: NOP, valid: 1'b0};
    end else if (load) begin
      q <= '{pc: load_pc, ir: load_ir, valid: 1'b1};
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// Fetch-side PC and FD-latch owner: issues imem requests, squashes
// wrong-path words on redirect, skids one response across stalls.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP      = NOP_WORD
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  fetch_redirect_if.master imem,
  output logic [XLEN-1:0] fd_pc,
  output logic [XLEN-1:0] fd_pc_plus1,
  output logic [XLEN-1:0] fd_ir,
  output logic            fd_valid,
  output logic            flush_dx
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc;
  fd_t             fd;
  fd_t             skid_q;

  logic in_fetch, in_hold, in_disc;
  logic take, fd_load, skid_load;
  logic drain, bubble;

  assign in_fetch = (state == FETCH);
  assign in_hold  = (state == HOLD);
  assign in_disc  = (state == DISCARD);

  // valid outside FETCH/DISCARD is ignored
  assign take      = in_fetch && imem.imem_valid && !redirect;
  assign fd_load   = take && !stall;
  assign skid_load = take && stall;
  assign drain     = in_hold && !stall && !redirect;
  assign bubble    = redirect
                   || (!stall && in_fetch && !imem.imem_valid)
                   || (!stall && in_disc);

  assign imem.imem_req  = reset && in_fetch;
  assign imem.imem_addr = pc;

  assign flush_dx    = redirect;
  assign fd_pc       = fd.pc;
  assign fd_pc_plus1 = fd.pc + 32'd1;
  assign fd_ir       = fd.ir;
  assign fd_valid    = fd.valid;

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (redirect)
          state_nxt = imem.imem_valid ? FETCH : DISCARD;
        else if (imem.imem_valid && stall)
          state_nxt = HOLD;
      end
      HOLD: begin
        if (redirect || !stall)
          state_nxt = FETCH;
      end
      DISCARD: begin
        if (imem.imem_valid)
          state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        pc <= RESET_PC;
    else if (redirect) pc <= redirect_pc;
    else if (take)     pc <= pc + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fd <= '{pc: '0, ir: NOP, valid: 1'b0};
    end else begin
      unique case (1'b1)
        fd_load: fd <= '{pc: pc, ir: imem.imem_rdata, valid: 1'b1};
        drain:   fd <= skid_q;
        bubble: begin
          fd.ir    <= NOP;
          fd.valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  fetch_skid_buf #(
    .NOP (NOP)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load    (skid_load),
    .drain   (drain),
    .clear   (redirect),
    .load_pc (pc),
    .load_ir (imem.imem_rdata),
    .q       (skid_q)
  );

endmodule

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- Fetch-side PC and FD-latch owner for the 5-stage pipeline.
- Consumes the branch/jump resolution outputs from execute: redirect flag (BorJ) and the redirect target PC.
- Issues word-addressed instruction-memory requests with a single outstanding request and a variable-latency valid handshake.
- Fills the FD latch, squashes wrong-path instructions on redirect, and holds one early response in a skid register during hazard stalls.

Parameters:
- RESET_PC, 32'd0: PC loaded on reset.
- NOP, 32'd0: instruction word injected into FD on squash or reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- redirect  in  1  BorJ from execute; PC must change this cycle.
- redirect_pc  in  32  target PC from execute (pc_out_cont).
- stall  in  1  hazard unit; FD must hold.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of the request.
- imem_valid  in  1  response strobe for the outstanding request.
- imem_rdata  in  32  instruction word, qualified by imem_valid.
- fd_pc  out  32  PC of the instruction in FD.
- fd_pc_plus1  out  32  fd_pc+1 (advanced_pc for decode/execute).
- fd_ir  out  32  instruction in FD.
- fd_valid  out  1  FD holds a real instruction.
- flush_dx  out  1  combinational copy of redirect; DX latch loads NOP at the next edge.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC; fd_pc=0; fd_ir=NOP; fd_valid=0; hold buffer empty; state=FETCH.
  - imem_req=0 while reset is low. First request issues in the first cycle after release.
- PC arithmetic: 32-bit, word-addressed, increment by 1, wraps 0xFFFFFFFF to 0. fd_pc_plus1 wraps the same way.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_valid, no stall, no redirect: next edge loads fd_ir=imem_rdata, fd_pc=pc, fd_valid=1, pc=pc+1. A new request issues the following cycle.
  - If imem_valid and stall (no redirect): capture {pc, rdata} in the hold buffer, pc=pc+1, FD unchanged, go HOLD.
  - If no imem_valid: remain in FETCH; FD holds if stall, otherwise FD becomes a bubble (fd_ir=NOP, fd_valid=0).
- HOLD:
  - imem_req=0.
  - When stall drops: the hold buffer moves into FD at the next edge, buffer empties, go FETCH.
- DISCARD (a request was outstanding when redirect arrived):
  - imem_req=0; the stale response is awaited.
  - When imem_valid arrives, drop the data and go FETCH (pc already holds the target).
  - FD stays bubble.
- Redirect (highest priority, every state):
  - At the next edge: pc=redirect_pc; fd_ir=NOP; fd_valid=0; hold buffer cleared. This overrides stall.
  - State after redirect:
    - FETCH without imem_valid this cycle: go DISCARD.
    - FETCH with imem_valid the same cycle: drop the data, go FETCH.
    - HOLD: go FETCH.
    - DISCARD: stay DISCARD unless imem_valid this cycle, then go FETCH.
  - flush_dx = redirect, same cycle.
- Back-to-back redirects: the later target wins. The DISCARD invariant of at most one outstanding request is preserved.
- imem_valid outside FETCH/DISCARD is a protocol error; it is ignored and never loads FD.
- Reset asserted mid-request: state is cleared immediately. A response arriving after reset release, before the first new request, is ignored because imem_req was 0.

Decomposition:
- Shared package: state encoding (FETCH, HOLD, DISCARD), NOP word, RESET_PC, instruction width constant.
- One sub-module is natural: fetch_skid_buf, a one-entry {pc, ir, valid} holding register with load/drain/clear.

Test Plan:
- Reset release with 1-cycle imem latency, no stall: imem_addr 0,1,2 on successive requests; fd_pc 0,1,2 with fd_ir equal to the memory words; fd_pc_plus1=fd_pc+1.
- Response during stall: stall=1 as word @5 returns -> FD keeps @4, imem_req=0; stall drops -> fd_pc=5 next edge; next request @6.
- Redirect with no outstanding response: redirect=1, redirect_pc=0x40 -> flush_dx=1 same cycle; next edge fd_valid=0, fd_ir=NOP; next request @0x40.
- Redirect while a 3-cycle request @9 is in flight: DISCARD; stale word is dropped, never in FD; request @0x80 issues only after the stale imem_valid.
- Redirect and stall together with the hold buffer full: redirect wins; buffer cleared; fetch resumes at redirect_pc; the held word never reaches FD.
- PC wrap: redirect_pc=0xFFFFFFFF -> after fetch fd_pc=0xFFFFFFFF, fd_pc_plus1=0, next imem_addr=0. Assert reset mid-fetch -> fd_valid=0 immediately, restart at RESET_PC.
